// File: rtl/overdrive_pregain_if.sv
// Sample/gain bundle between the drive source and the pre-gain stage.
// master drives in_*, slave (the pre-gain) drives ou_*.
interface overdrive_pregain_if #(
  parameter int WIDTH = 32,
  parameter int GW    = 16
);
  logic                    in_valid;
  logic signed [WIDTH-1:0] in_sample;
  logic [GW-1:0]           in_gain;
  logic                    ou_valid;
  logic signed [WIDTH-1:0] ou_sample;
  logic                    ou_sat;

  modport master (
    output in_valid,
    output in_sample,
    output in_gain,
    input  ou_valid,
    input  ou_sample,
    input  ou_sat
  );

  modport slave (
    input  in_valid,
    input  in_sample,
    input  in_gain,
    output ou_valid,
    output ou_sample,
    output ou_sat
  );
endinterface

// File: rtl/overdrive_pregain.sv
// Drive pre-gain: sample x slewed gain, /One toward zero, clamp to +-SAT_LIMIT.
// Ports: clk, rst_n (async low), bus (slave: in_valid/sample/gain -> ou_valid/sample/sat).
module overdrive_pregain #(
  parameter int WIDTH     = 32,
  parameter int FRAC      = 12,
  parameter int GW        = 16,
  parameter int STEP      = 256,
  parameter int SAT_LIMIT = 8192
) (
  input logic                clk,
  input logic                rst_n,
  overdrive_pregain_if.slave bus
);

  localparam int PW = WIDTH + GW + 1;
  localparam int QW = PW - FRAC;

  localparam logic [GW-1:0] ONE    = GW'(1 << FRAC);
  localparam logic [GW-1:0] STEP_G = GW'(STEP);

  localparam logic signed [QW-1:0] SAT_P = QW'(SAT_LIMIT);
  localparam logic signed [QW-1:0] SAT_N = -SAT_P;

  logic [GW-1:0]           gain_q, gain_d;
  logic                    v1_q, v1_d;
  logic signed [PW-1:0]    p_q, p_d;
  logic                    v2_q, v2_d;
  logic signed [QW-1:0]    qt_q, qt_d;
  logic                    v3_q, v3_d;
  logic signed [WIDTH-1:0] smp_q, smp_d;
  logic                    sat_q, sat_d;

  logic signed [PW-1:0] smp_x;
  logic signed [PW-1:0] gain_x;
  logic signed [QW-1:0] q_fl;
  logic [QW-1:0]        q_rnd;

  // Gain ramp: at most one STEP toward target per accepted sample.
  always_comb begin
    gain_d = gain_q;
    if (bus.in_valid) begin
      if (gain_q < bus.in_gain) begin
        if (bus.in_gain - gain_q > STEP_G)
          gain_d = gain_q + STEP_G;
        else
          gain_d = bus.in_gain;
      end else if (gain_q > bus.in_gain) begin
        if (gain_q - bus.in_gain > STEP_G)
          gain_d = gain_q - STEP_G;
        else
          gain_d = bus.in_gain;
      end
    end
  end

  // Stage 1: full-width product with the pre-update gain.
  always_comb begin
    smp_x = $signed({{(PW-WIDTH){bus.in_sample[WIDTH-1]}},
                     bus.in_sample});
    gain_x = $signed({{(PW-GW){1'b0}}, gain_q});
    v1_d = bus.in_valid;
    p_d  = p_q;
    if (bus.in_valid)
      p_d = smp_x * gain_x;
  end

  // Stage 2: divide by One toward zero. The shift floors, so a
  // negative product with a nonzero fraction gets +1 back.
  always_comb begin
    q_fl  = $signed(p_q[PW-1:FRAC]);
    q_rnd = {{(QW-1){1'b0}},
             p_q[PW-1] & (|p_q[FRAC-1:0])};
    v2_d  = v1_q;
    qt_d  = qt_q;
    if (v1_q)
      qt_d = $signed(q_fl + q_rnd);
  end

  // Output: clamp; exactly +-SAT_LIMIT passes unflagged.
  always_comb begin
    v3_d  = v2_q;
    smp_d = smp_q;
    sat_d = sat_q;
    if (v2_q) begin
      unique case (1'b1)
        (qt_q > SAT_P): begin
          smp_d = WIDTH'(SAT_P);
          sat_d = 1'b1;
        end
        (qt_q < SAT_N): begin
          smp_d = WIDTH'(SAT_N);
          sat_d = 1'b1;
        end
        default: begin
          smp_d = qt_q[WIDTH-1:0];
          sat_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gain_q <= ONE;
      v1_q   <= 1'b0;
      p_q    <= '0;
      v2_q   <= 1'b0;
      qt_q   <= '0;
      v3_q   <= 1'b0;
      smp_q  <= '0;
      sat_q  <= 1'b0;
    end else begin
      gain_q <= gain_d;
      v1_q   <= v1_d;
      p_q    <= p_d;
      v2_q   <= v2_d;
      qt_q   <= qt_d;
      v3_q   <= v3_d;
      smp_q  <= smp_d;
      sat_q  <= sat_d;
    end
  end

  assign bus.ou_valid  = v3_q;
  assign bus.ou_sample = smp_q;
  assign bus.ou_sat    = sat_q;

endmodule

// File: tb/tb_overdrive_pregain.sv
// Bench for overdrive_pregain: vector table, directed corners,
// and random traffic scored against an arithmetic model.
module tb_overdrive_pregain;

  typedef struct {
    logic signed [31:0] s;
    logic [15:0]        g;
    int                 exp;
    bit                 sat;
  } vec_t;

  typedef struct {
    int due;
    int s;
    bit sat;
  } exp_t;

  logic clk;
  logic rst_n;
  int   ncyc;
  int   errors;
  int   checks;
  bit   run;
  int   mg;
  int   last_s;
  bit   last_sat;
  exp_t sbq[$];
  vec_t tbl[$];

  overdrive_pregain_if #(.WIDTH(32), .GW(16)) bus ();

  overdrive_pregain dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) ncyc <= ncyc + 1;

  task automatic chk(input string nm, input longint act,
                     input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d",
               nm, act, req, ncyc);
    end
  endtask

  // Scoreboard: every negedge, compare against model output.
  always @(negedge clk) begin
    if (run) begin
      bit ev;
      ev = (sbq.size() > 0) && (sbq[0].due == ncyc);
      if (ev) begin
        last_s   = sbq[0].s;
        last_sat = sbq[0].sat;
        void'(sbq.pop_front());
      end
      chk("sb_valid", longint'(bus.ou_valid), longint'(ev));
      chk("sb_sample", longint'(bus.ou_sample), longint'(last_s));
      chk("sb_sat", longint'(bus.ou_sat), longint'(last_sat));
    end
  end

  task automatic drive(input bit v, input logic signed [31:0] s,
                       input logic [15:0] g);
    longint p;
    longint q;
    int     gi;
    exp_t   e;
    @(posedge clk);
    #2;
    bus.in_valid  = v;
    bus.in_sample = s;
    bus.in_gain   = g;
    if (v) begin
      p = longint'(s) * longint'(mg);
      q = p / 4096;
      e.due = ncyc + 3;
      if (q > 8192) begin
        e.s = 8192; e.sat = 1'b1;
      end else if (q < -8192) begin
        e.s = -8192; e.sat = 1'b1;
      end else begin
        e.s = int'(q); e.sat = 1'b0;
      end
      sbq.push_back(e);
      gi = int'(g);
      if (mg < gi)
        mg = (gi - mg > 256) ? mg + 256 : gi;
      else if (mg > gi)
        mg = (mg - gi > 256) ? mg - 256 : gi;
    end
  endtask

  task automatic idle();
    drive(1'b0, 32'sd0, bus.in_gain);
  endtask

  task automatic settle(input logic [15:0] g);
    for (int i = 0; i < 40; i++) drive(1'b1, 32'sd0, g);
    for (int i = 0; i < 3; i++) idle();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    sbq.delete();
    mg = 4096;
    last_s = 0;
    last_sat = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // One sample, then look at it directly on its output cycle.
  task automatic one_shot(input string nm, input logic signed [31:0] s,
                          input logic [15:0] g, input int ex,
                          input bit sx);
    drive(1'b1, s, g);
    for (int i = 0; i < 3; i++) idle();
    @(negedge clk);
    chk({nm, "_valid"}, longint'(bus.ou_valid), 1);
    chk({nm, "_sample"}, longint'(bus.ou_sample), longint'(ex));
    chk({nm, "_sat"}, longint'(bus.ou_sat), longint'(sx));
  endtask

  initial begin
    logic [15:0]        rg;
    logic signed [31:0] rs;
    bit                 rv;

    errors = 0; checks = 0; ncyc = 0; run = 1'b0;
    mg = 4096; last_s = 0; last_sat = 1'b0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_sample = '0;
    bus.in_gain = 16'd4096;

    tbl.push_back('{32'sd4096, 16'd8192, 8192, 1'b0});
    tbl.push_back('{32'sd5000, 16'd8192, 8192, 1'b1});
    tbl.push_back('{-32'sd5000, 16'd8192, -8192, 1'b1});
    tbl.push_back('{-32'sd4096, 16'd8192, -8192, 1'b0});
    tbl.push_back('{32'sd3, 16'd6144, 4, 1'b0});
    tbl.push_back('{-32'sd3, 16'd6144, -4, 1'b0});
    tbl.push_back('{-32'sd1, 16'd6144, -1, 1'b0});
    tbl.push_back('{32'sd1, 16'd6144, 1, 1'b0});
    tbl.push_back('{-32'sd2, 16'd6144, -3, 1'b0});
    tbl.push_back('{-32'sd8192, 16'd4096, -8192, 1'b0});
    tbl.push_back('{-32'sd8193, 16'd4096, -8192, 1'b1});
    tbl.push_back('{32'sd8193, 16'd4096, 8192, 1'b1});
    tbl.push_back('{32'sd12345, 16'd0, 0, 1'b0});

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", longint'(bus.ou_valid), 0);
    chk("rst_sample", longint'(bus.ou_sample), 0);
    chk("rst_sat", longint'(bus.ou_sat), 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    run = 1'b1;

    one_shot("unity", 32'sd1000, 16'd4096, 1000, 1'b0);

    for (int i = 0; i < 20; i++) drive(1'b1, 32'sd4096, 16'd8192);
    for (int i = 0; i < 3; i++) idle();
    chk("ramp_gain", longint'(mg), 8192);

    settle(16'd4096);
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 32'sd4096, 16'd8192);
      idle();
      idle();
    end
    for (int i = 0; i < 3; i++) idle();

    for (int i = 0; i < tbl.size(); i++) begin
      settle(tbl[i].g);
      one_shot($sformatf("vec%0d", i), tbl[i].s, tbl[i].g,
               tbl[i].exp, tbl[i].sat);
    end

    settle(16'd4096);
    drive(1'b1, 32'sd4096, 16'd8192);
    drive(1'b1, 32'sd4096, 16'd8192);
    do_reset();
    for (int i = 0; i < 4; i++) idle();
    one_shot("post_rst", 32'sd4096, 16'd8192, 4096, 1'b0);

    rg = 16'd4096;
    for (int i = 0; i < 600; i++) begin
      rv = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0)
        rs = $signed($urandom);
      else
        rs = $signed(32'($urandom_range(0, 40000)) - 32'd20000);
      if ($urandom_range(0, 15) == 0) begin
        if ($urandom_range(0, 3) == 0)
          rg = 16'($urandom);
        else
          rg = 16'($urandom_range(0, 16384));
      end
      drive(rv, rs, rg);
      if (i == 300) begin
        do_reset();
        rg = 16'd4096;
      end
    end
    for (int i = 0; i < 5; i++) idle();
    chk("drain", longint'(sbq.size()), 0);

    run = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
